// File: rtl/ucus_ortami_surucu.sv
// Flight environment / command driver facing the autopilot: altitude model, sensor feedback, command strobe and outcome.
// Optional altimeter noise when FLIGHT_NOISE_EN is defined. Accept to first response check: 2 edges.
module ucus_ortami_surucu #(
    parameter int          CLIMB_DIV   = 4,
    parameter int          SINK_DIV    = 8,
    parameter int          TIMEOUT_CYC = 256,
    parameter logic [5:0]  INIT_ALT    = 6'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_alt,
    output logic [18:0] ap_io_in,
    input  logic [2:0]  ap_io_out,
    output logic [5:0]  alt_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic        fault_latched_o
);

    localparam int              TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [5:0]      CLIMB_LAST = 6'(CLIMB_DIV - 1);
    localparam logic [5:0]      SINK_LAST  = 6'(SINK_DIV - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_REACHED = 2'b01;
    localparam logic [1:0] ST_FAULT   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    logic motor, green, red;
    assign motor = ap_io_out[0];
    assign green = ap_io_out[1];
    assign red   = ap_io_out[2];

    // ------------------------------------------------------------------
    // Altitude model
    // ------------------------------------------------------------------
    logic [5:0] alt;
    logic [5:0] prescaler;
    logic [5:0] div_last;
    logic       motor_prev;

    always_comb begin
        div_last = SINK_LAST;
        if (motor) div_last = CLIMB_LAST;
    end

    // motor_prev follows the input even in reset so a motor held steady
    // through reset does not look like a toggle on the first edge.
    always_ff @(posedge clk) begin
        motor_prev <= motor;
        if (rst) begin
            alt       <= INIT_ALT;
            prescaler <= 6'd0;
        end else if (motor != motor_prev) begin
            prescaler <= 6'd0;
        end else if (prescaler == div_last) begin
            prescaler <= 6'd0;
            if (motor && alt != 6'd63)
                alt <= alt + 6'd1;
            else if (!motor && alt != 6'd0)
                alt <= alt - 6'd1;
        end else begin
            prescaler <= prescaler + 6'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sensors
    // ------------------------------------------------------------------
    logic [5:0] gnss;
    logic [5:0] altim;
    logic [5:0] altim_next;

`ifdef FLIGHT_NOISE_EN
    logic [7:0] lfsr;
    logic [6:0] altim_sum;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 8'hA5;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_comb begin
        altim_sum  = {1'b0, alt} + {5'b0, lfsr[1:0]};
        altim_next = altim_sum[5:0];
        if (altim_sum[6]) altim_next = 6'd63;
    end
`else
    always_comb begin
        altim_next = alt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            gnss  <= INIT_ALT;
            altim <= INIT_ALT;
        end else begin
            gnss  <= alt;
            altim <= altim_next;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    state_t        state;
    logic [5:0]    target;
    logic          strobe;
    logic [TW-1:0] timer;
    logic          done_r;
    logic [1:0]    status_r;
    logic          ready_r;

    // Completion leaves ready low for the done cycle; it rises one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ready_r  <= 1'b1;
            target   <= 6'd0;
            strobe   <= 1'b0;
            timer    <= '0;
            done_r   <= 1'b0;
            status_r <= 2'b00;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && ready_r) begin
                        target  <= cmd_alt;
                        strobe  <= 1'b1;
                        timer   <= '0;
                        ready_r <= 1'b0;
                        state   <= S_WAIT;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (strobe) begin
                        strobe <= 1'b0;
                    end else if (red) begin
                        status_r <= ST_FAULT;
                        done_r   <= 1'b1;
                        state    <= S_IDLE;
                    end else if (green) begin
                        status_r <= ST_REACHED;
                        done_r   <= 1'b1;
                        state    <= S_IDLE;
                    end else if (timer == TIMER_LAST) begin
                        status_r <= ST_TIMEOUT;
                        done_r   <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            fault_latched_o <= 1'b0;
        else if (red)
            fault_latched_o <= 1'b1;
    end

    assign cmd_ready = ready_r;
    assign done_o    = done_r;
    assign status_o  = status_r;
    assign alt_o     = alt;
    assign ap_io_in  = {strobe, target, altim, gnss};

endmodule
